// File: rtl/store_unit.sv
// store_unit: MEM-stage store buffer; encodes SB/SH/SW into a 2-entry FIFO and drains it onto a req/addr_ok/data_ok write bus.
// Optional STORE_ALIGN_CHECK_EN: misaligned SH/SW raise adesM instead of being address-masked.
module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        store_validM,
  input  logic [7:0]  alucontrolM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  input  logic        flushM,
  output logic        stall_storeM,
  output logic        adesM,
  output logic        buf_empty,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);
  localparam logic [7:0] EXE_SB_OP = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP = 8'b1110_1011;
  localparam logic [1:0] FULL      = 2'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } st_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  st_entry_t   entry_q [DEPTH];
  st_entry_t   entry_d [DEPTH];
  st_entry_t   new_e, head;
  logic        is_sb, is_sh, is_sw, st_op, full, push, pop;
  logic [31:0] eff_addr;

  assign is_sb = (alucontrolM == EXE_SB_OP);
  assign is_sh = (alucontrolM == EXE_SH_OP);
  assign is_sw = (alucontrolM == EXE_SW_OP);
  assign st_op = store_validM & (is_sb | is_sh | is_sw);
  assign full  = (count_q == FULL);

`ifdef STORE_ALIGN_CHECK_EN
  assign adesM    = st_op & ~flushM & ((is_sh & addrM[0]) | (is_sw & (addrM[1:0] != 2'b00)));
  assign eff_addr = addrM;
`else
  assign adesM = 1'b0;
  // Misaligned halfword/word stores are forced to natural alignment.
  always_comb begin
    eff_addr = addrM;
    if (is_sw)      eff_addr[1:0] = 2'b00;
    else if (is_sh) eff_addr[0]   = 1'b0;
  end
`endif

  always_comb begin
    new_e.addr  = eff_addr;
    new_e.size  = 2'd2;
    new_e.wstrb = 4'b1111;
    new_e.wdata = writedataM;
    if (is_sb) begin
      new_e.size  = 2'd0;
      new_e.wstrb = 4'b0001 << eff_addr[1:0];
      new_e.wdata = {4{writedataM[7:0]}};
    end else if (is_sh) begin
      new_e.size  = 2'd1;
      new_e.wstrb = eff_addr[1] ? 4'b1100 : 4'b0011;
      new_e.wdata = {2{writedataM[15:0]}};
    end
  end

  // No pop-and-push while full: stall depends only on MEM inputs and count.
  assign stall_storeM = st_op & ~flushM & ~adesM & full;
  assign push         = st_op & ~flushM & ~adesM & ~full;
  assign pop          = (state_q == S_WAIT) & data_data_ok;

  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      entry_d[wr_ptr_q] = new_e;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (count_q != 2'd0) state_d = S_REQ;
      S_REQ:   if (data_addr_ok)    state_d = S_WAIT;
      S_WAIT:  if (data_data_ok)    state_d = (count_d != 2'd0) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      entry_q  <= entry_d;
    end
  end

  // Head slot is untouched until its data_ok, so bus fields hold through REQ.
  assign head       = entry_q[rd_ptr_q];
  assign data_req   = (state_q == S_REQ);
  assign data_wr    = data_req;
  assign data_addr  = head.addr;
  assign data_size  = head.size;
  assign data_wstrb = head.wstrb;
  assign data_wdata = head.wdata;
  assign buf_empty  = (count_q == 2'd0) & (state_q == S_IDLE);
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed protocol tests plus a randomized scoreboard run against a queue-based reference model.
module tb_store_unit;
  localparam logic [7:0] OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB, OP_OTHER = 8'h21;
`ifdef STORE_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0, resetn = 1'b1;
  logic        store_validM = 1'b0, flushM = 1'b0, data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [7:0]  alucontrolM = 8'h0;
  logic [31:0] addrM = 32'h0, writedataM = 32'h0;
  logic        stall_storeM, adesM, buf_empty, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;

  store_unit #(.DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .store_validM(store_validM), .alucontrolM(alucontrolM),
    .addrM(addrM), .writedataM(writedataM), .flushM(flushM), .stall_storeM(stall_storeM),
    .adesM(adesM), .buf_empty(buf_empty), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0, mcount = 0;
  bit   outstanding = 0, mon_en = 0, drv_enq = 0, exp_stall = 0, exp_ades = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference encoding from the lane rules, using plain arithmetic.
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int unsigned lane;
    if (op == OP_SB) begin
      e.addr = a; lane = a % 4;
      e.size = 2'd0; e.wstrb = 4'(1 << lane);
      e.wdata = {24'd0, wd[7:0]} * 32'h0101_0101;
    end else if (op == OP_SH) begin
      e.addr = a - (a % 2); lane = e.addr % 4;
      e.size = 2'd1; e.wstrb = 4'(3 << lane);
      e.wdata = {16'd0, wd[15:0]} * 32'h0001_0001;
    end else begin
      e.addr = a - (a % 4);
      e.size = 2'd2; e.wstrb = 4'hF; e.wdata = wd;
    end
    return e;
  endfunction

  function automatic bit is_store(input logic [7:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic bit fault(input logic [7:0] op, input logic [31:0] a);
    return ALIGN_CHK && ((op == OP_SH && a % 2 != 0) || (op == OP_SW && a % 4 != 0));
  endfunction

  task automatic drive_store(input logic v, input logic [7:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input logic fl);
    bit st, ad;
    store_validM = v; alucontrolM = op; addrM = a; writedataM = wd; flushM = fl;
    st = v && is_store(op);
    ad = st && !fl && fault(op, a);
    exp_ades  = ad;
    exp_stall = st && !fl && !ad && mcount == 2;
    drv_enq   = st && !fl && !ad && mcount < 2;
    if (mon_en && drv_enq) exp_q.push_back(model(op, a, wd));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive_store(1'b0, OP_OTHER, 32'h0, 32'h0, 1'b0);
  endtask

  // Monitor: compares DUT outputs with the model and retires scoreboard entries on handshakes.
  always @(negedge clk) begin
    if (mon_en && resetn) begin
      chk("buf_empty", 32'(buf_empty), 32'(mcount == 0));
      chk("stall", 32'(stall_storeM), 32'(exp_stall));
      chk("ades", 32'(adesM), 32'(exp_ades));
      chk("data_wr", 32'(data_wr), 32'(data_req));
      if (data_req) begin
        if (outstanding || mcount == 0 || exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_protocol actual=req required=no_req (mcount=%0d)", mcount);
        end else begin
          chk("req_addr", data_addr, exp_q[0].addr);
          chk("req_size", 32'(data_size), 32'(exp_q[0].size));
          chk("req_wstrb", 32'(data_wstrb), 32'(exp_q[0].wstrb));
          chk("req_wdata", data_wdata, exp_q[0].wdata);
        end
      end
      if (data_req && data_addr_ok && !outstanding && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        outstanding = 1;
      end else if (outstanding && data_data_ok) begin
        outstanding = 0;
        mcount--;
      end
      if (drv_enq) mcount++;
    end
  end

  task automatic single(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ea, input logic [1:0] es, input logic [3:0] eb, input logic [31:0] ed);
    data_addr_ok = 1; data_data_ok = 1;
    drive_store(1'b1, op, a, wd, 1'b0);
    step(); idle();
    @(negedge clk);
    chk({nm, "_lat_req"}, 32'(data_req), 32'd0);
    chk({nm, "_lat_empty"}, 32'(buf_empty), 32'd0);
    step();
    @(negedge clk);
    chk({nm, "_req"}, 32'(data_req), 32'd1);
    chk({nm, "_wr"}, 32'(data_wr), 32'd1);
    chk({nm, "_addr"}, data_addr, ea);
    chk({nm, "_size"}, 32'(data_size), 32'(es));
    chk({nm, "_wstrb"}, 32'(data_wstrb), 32'(eb));
    chk({nm, "_wdata"}, data_wdata, ed);
    step();
    @(negedge clk);
    chk({nm, "_wait_req"}, 32'(data_req), 32'd0);
    chk({nm, "_wait_empty"}, 32'(buf_empty), 32'd0);
    step();
    @(negedge clk);
    chk({nm, "_done_empty"}, 32'(buf_empty), 32'd1);
    step();
  endtask

  task automatic full_stall();
    logic [31:0] got[$];
    bit c_held, c_go;
    int drop_at;
    c_held = 1; c_go = 0; drop_at = -1;
    data_addr_ok = 0; data_data_ok = 0;
    drive_store(1'b1, OP_SW, 32'h100, 32'h11, 1'b0); step();
    drive_store(1'b1, OP_SW, 32'h104, 32'h22, 1'b0); step();
    drive_store(1'b1, OP_SW, 32'h108, 32'h33, 1'b0);
    @(negedge clk); chk("full_stall1", 32'(stall_storeM), 32'd1);
    step();
    @(negedge clk); chk("full_stall2", 32'(stall_storeM), 32'd1);
    step();
    data_addr_ok = 1; data_data_ok = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (c_held && !stall_storeM && !c_go) begin c_go = 1; drop_at = got.size(); end
      if (data_req && data_addr_ok) got.push_back(data_addr);
      step();
      if (c_go && c_held) begin c_held = 0; idle(); end
    end
    chk("full_c_after_pop", 32'(drop_at), 32'd1);
    chk("full_nreq", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("full_ord0", got[0], 32'h100);
      chk("full_ord1", got[1], 32'h104);
      chk("full_ord2", got[2], 32'h108);
    end
    @(negedge clk); chk("full_empty", 32'(buf_empty), 32'd1);
    step();
  endtask

  task automatic flush_test();
    logic [31:0] got[$];
    data_addr_ok = 0; data_data_ok = 0;
    drive_store(1'b1, OP_SW, 32'h200, 32'h1, 1'b0); step();
    drive_store(1'b1, OP_SW, 32'h204, 32'h2, 1'b0); step();
    drive_store(1'b1, OP_SW, 32'h208, 32'h3, 1'b1);
    @(negedge clk);
    chk("flush_full_stall", 32'(stall_storeM), 32'd0);
    step(); idle();
    data_addr_ok = 1; data_data_ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_req && data_addr_ok) got.push_back(data_addr);
      step();
    end
    chk("flush_nreq", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("flush_ord0", got[0], 32'h200);
      chk("flush_ord1", got[1], 32'h204);
    end
    drive_store(1'b1, OP_SW, 32'h20C, 32'h4, 1'b1);
    step(); idle();
    @(negedge clk); chk("flush_empty", 32'(buf_empty), 32'd1);
    step();
    @(negedge clk); chk("flush_noreq", 32'(data_req), 32'd0);
    step();
  endtask

  task automatic reset_mid();
    data_addr_ok = 0; data_data_ok = 0;
    drive_store(1'b1, OP_SW, 32'h300, 32'h5, 1'b0); step();
    drive_store(1'b1, OP_SW, 32'h304, 32'h6, 1'b0); step(); idle();
    @(negedge clk); chk("rst_pre_req", 32'(data_req), 32'd1);
    data_addr_ok = 1;
    step(); data_addr_ok = 0;
    @(negedge clk);
    chk("rst_wait_req", 32'(data_req), 32'd0);
    chk("rst_wait_nempty", 32'(buf_empty), 32'd0);
    #1 resetn = 0;
    #1 chk("rst_async_req", 32'(data_req), 32'd0);
    chk("rst_async_empty", 32'(buf_empty), 32'd1);
    step(); step(); resetn = 1;
    data_data_ok = 1; data_addr_ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_after_req", 32'(data_req), 32'd0);
      chk("rst_after_empty", 32'(buf_empty), 32'd1);
      step();
    end
    data_addr_ok = 0; data_data_ok = 0;
    drive_store(1'b1, OP_SB, 32'h400, 32'h7, 1'b0); step(); idle(); step();
    @(negedge clk); chk("rst_req_up", 32'(data_req), 32'd1);
    #1 resetn = 0;
    #1 chk("rst_req_drop", 32'(data_req), 32'd0);
    step(); resetn = 1; step();
  endtask

  task automatic random_run();
    logic [7:0] op;
    int unsigned r;
    @(posedge clk); #1 resetn = 0;
    mcount = 0; outstanding = 0; exp_q.delete();
    mon_en = 1; idle();
    data_addr_ok = 0; data_data_ok = 0;
    step(); resetn = 1;
    for (int c = 0; c < 3000; c++) begin
      r  = $urandom_range(0, 7);
      op = (r < 2) ? OP_SB : (r < 4) ? OP_SH : (r < 7) ? OP_SW : OP_OTHER;
      drive_store(1'($urandom_range(0, 1)), op, $urandom, $urandom, 1'($urandom_range(0, 7) == 0));
      data_addr_ok = 1'($urandom_range(0, 2) != 0);
      data_data_ok = 1'($urandom_range(0, 1));
      step();
    end
    for (int c = 0; c < 40; c++) begin
      idle(); data_addr_ok = 1; data_data_ok = 1;
      step();
    end
    @(negedge clk);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_count", 32'(mcount), 32'd0);
    mon_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1 resetn = 0;
    #1;
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    chk("rst_stall", 32'(stall_storeM), 32'd0);
    chk("rst_ades", 32'(adesM), 32'd0);
    chk("rst_empty", 32'(buf_empty), 32'd1);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_size", 32'(data_size), 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    step(); step(); resetn = 1; step();

    single("sb", OP_SB, 32'h1003, 32'h0000_00A5, 32'h1003, 2'd0, 4'b1000, 32'hA5A5_A5A5);
    single("sh", OP_SH, 32'h2002, 32'h1234_BEEF, 32'h2002, 2'd1, 4'b1100, 32'hBEEF_BEEF);
`ifdef STORE_ALIGN_CHECK_EN
    drive_store(1'b1, OP_SW, 32'h3001, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    chk("mis_ades", 32'(adesM), 32'd1);
    chk("mis_stall", 32'(stall_storeM), 32'd0);
    step(); idle();
    @(negedge clk); chk("mis_empty", 32'(buf_empty), 32'd1);
    step();
    @(negedge clk); chk("mis_noreq", 32'(data_req), 32'd0);
    step();
`else
    single("sw_mis", OP_SW, 32'h3001, 32'hCAFE_F00D, 32'h3000, 2'd2, 4'b1111, 32'hCAFE_F00D);
`endif
    full_stall();
    flush_test();
    reset_mid();
    random_run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
